// File: rtl/value_delay_pipe.sv
// Elastic DELAY-stage delay line for VALUE_SIZE-bit values; `VALUE_DELAY_BUBBLE_COLLAPSE_EN selects per-stage advance (bubble collapse), default is global stall.
// Latency: DELAY cycles from presentation to out_valid when unstalled; one entry per cycle while out_ready=1.
// Backpressure: in_ready is combinational from out_ready/flush/state; a stall freezes the line (or only the stages ahead of the nearest bubble).
module value_delay_pipe #(
  parameter int VALUE_SIZE = 32,
  parameter int DELAY = 4,
  localparam int CNT_W = $clog2(DELAY + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VALUE_SIZE-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VALUE_SIZE-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy
);

  logic [DELAY-1:0]      stage_vld_q, stage_vld_d;
  logic [VALUE_SIZE-1:0] stage_dat_q [DELAY];
  logic [VALUE_SIZE-1:0] stage_dat_d [DELAY];
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [DELAY-1:0]      adv;
  logic                  in_hs, out_hs;

  always_comb begin
    adv = '0;
`ifdef VALUE_DELAY_BUBBLE_COLLAPSE_EN
    // Stage i may move when any stage from i to the output end is empty.
    for (int i = 0; i < DELAY; i++) begin
      adv[i] = out_ready | (|(~stage_vld_q & ({DELAY{1'b1}} << i)));
    end
`else
    adv = {DELAY{~stage_vld_q[DELAY-1] | out_ready}};
`endif
  end

  assign in_ready  = resetn & ~flush & adv[0];
  assign out_valid = stage_vld_q[DELAY-1] & ~flush;
  assign out_data  = stage_dat_q[DELAY-1];
  assign occupancy = occ_q;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  always_comb begin
    stage_vld_d = stage_vld_q;
    for (int i = 0; i < DELAY; i++) begin
      stage_dat_d[i] = stage_dat_q[i];
    end
    occ_d = occ_q + CNT_W'(in_hs) - CNT_W'(out_hs);
    if (flush) begin
      // Data is left in place; only the valid bits are dropped.
      stage_vld_d = '0;
      occ_d       = '0;
    end else begin
      if (adv[0]) begin
        stage_vld_d[0] = in_valid;
        stage_dat_d[0] = in_data;
      end
      for (int i = 1; i < DELAY; i++) begin
        if (adv[i]) begin
          stage_vld_d[i] = stage_vld_q[i-1];
          stage_dat_d[i] = stage_dat_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_vld_q <= '0;
      occ_q       <= '0;
      for (int i = 0; i < DELAY; i++) begin
        stage_dat_q[i] <= '0;
      end
    end else begin
      stage_vld_q <= stage_vld_d;
      occ_q       <= occ_d;
      for (int i = 0; i < DELAY; i++) begin
        stage_dat_q[i] <= stage_dat_d[i];
      end
    end
  end

endmodule

// File: tb/tb_value_delay_pipe.sv
// Bench for value_delay_pipe: a DELAY=4 and a DELAY=1 instance checked against a slot-list model every cycle,
// plus directed scenarios with literal expectations. Honours `VALUE_DELAY_BUBBLE_COLLAPSE_EN like the design.
module tb_value_delay_pipe;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } ent_t;

  localparam logic [31:0] VA = 32'hA0A0_0001;
  localparam logic [31:0] VB = 32'hA0A0_0002;
  localparam logic [31:0] VC = 32'hA0A0_0003;
  localparam logic [31:0] VD = 32'hA0A0_0004;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush0, iv0, or0, ir0, ov0;
  logic [31:0] id0, od0;
  logic [2:0]  occ0;
  logic        flush1, iv1, or1, ir1, ov1;
  logic [31:0] id1, od1;
  logic [0:0]  occ1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m[k][0] is the output end, m[k][depth-1] the input end.
  ent_t m [2][4];

  value_delay_pipe #(.VALUE_SIZE(32), .DELAY(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .flush(flush0),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .occupancy(occ0)
  );

  value_delay_pipe #(.VALUE_SIZE(32), .DELAY(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .flush(flush1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .occupancy(occ1)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int depth(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++)
        m[k][j] = '0;
  endtask

  // One clock edge: either the head leaves (or is a bubble) and everything moves up,
  // or, when stalled, the bubble nearest the output is squeezed out (collapse mode only).
  task automatic model_step(input int k, input logic fl, input logic iv, input logic [31:0] id,
                            input logic ordy);
    int   n, b;
    ent_t e;
    n = depth(k);
    if (fl) begin
      for (int j = 0; j < n; j++) m[k][j].v = 1'b0;
    end else begin
      b = -1;
      if (!m[k][0].v || ordy) b = 0;
`ifdef VALUE_DELAY_BUBBLE_COLLAPSE_EN
      else begin
        for (int j = 0; j < n; j++)
          if (!m[k][j].v && b < 0) b = j;
      end
`endif
      if (b >= 0) begin
        for (int j = b; j < n - 1; j++) m[k][j] = m[k][j+1];
        e.v = iv;
        e.d = id;
        m[k][n-1] = e;
      end
    end
  endtask

  task automatic model_cmp(input int k, input logic fl, input logic ordy, input logic ov,
                           input logic [31:0] od, input logic ir, input logic [31:0] occ);
    int    n, pop;
    logic  bub, exp_ir;
    string p;
    p   = (k == 0) ? "model_d4" : "model_d1";
    n   = depth(k);
    pop = 0;
    bub = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (m[k][j].v) pop++;
      else bub = 1'b1;
    end
`ifdef VALUE_DELAY_BUBBLE_COLLAPSE_EN
    exp_ir = resetn & ~fl & (bub | ordy);
`else
    exp_ir = resetn & ~fl & (~m[k][0].v | ordy);
`endif
    check({p, "_out_valid"}, 32'(ov), 32'(m[k][0].v & ~fl));
    if (m[k][0].v && !fl) check({p, "_out_data"}, od, m[k][0].d);
    check({p, "_in_ready"}, 32'(ir), 32'(exp_ir));
    check({p, "_occupancy"}, occ, pop);
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_clear();
      else begin
        model_step(0, flush0, iv0, id0, or0);
        model_step(1, flush1, iv1, id1, or1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      model_cmp(0, flush0, or0, ov0, od0, ir0, 32'(occ0));
      model_cmp(1, flush1, or1, ov1, od1, ir1, 32'(occ1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    resetn = 1'b0;
    flush0 = 1'b0; iv0 = 1'b0; id0 = '0; or0 = 1'b1;
    flush1 = 1'b0; iv1 = 1'b0; id1 = '0; or1 = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 32'(ov0), 0);
    check("rst_out_data", od0, 0);
    check("rst_in_ready", 32'(ir0), 0);
    check("rst_occupancy", 32'(occ0), 0);
    resetn = 1'b1;

    // Reset alignment: stream 1,2,3,... with the consumer always ready.
    for (int k = 0; k < 12; k++) begin
      iv0 = 1'b1;
      id0 = k + 1;
      #1;
      check("t1_in_ready", 32'(ir0), 1);
      if (k >= 4) begin
        check("t1_stream_valid", 32'(ov0), 1);
        check("t1_stream_data", od0, k - 3);
      end else begin
        check("t1_fill_valid", 32'(ov0), 0);
      end
      if (k == 8) check("t1_occ_settled", 32'(occ0), 4);
      tick();
    end
    iv0 = 1'b0;
    repeat (5) tick();
    check("t1_drained", 32'(occ0), 0);

    // Stall: A, idle, B, idle, then hold the output for three cycles.
    iv0 = 1'b1; id0 = VA; tick();
    iv0 = 1'b0; tick();
    iv0 = 1'b1; id0 = VB; tick();
    iv0 = 1'b0; tick();
    or0 = 1'b0;
`ifdef VALUE_DELAY_BUBBLE_COLLAPSE_EN
    iv0 = 1'b1; id0 = VC; #1;
    check("t2c_in_ready_c", 32'(ir0), 1);
    check("t2c_head_a", od0, VA);
    check("t2c_occ_2", 32'(occ0), 2);
    tick();
    id0 = VD; #1;
    check("t2c_in_ready_d", 32'(ir0), 1);
    check("t2c_occ_3", 32'(occ0), 3);
    tick();
    iv0 = 1'b0; #1;
    check("t2c_in_ready_full", 32'(ir0), 0);
    check("t2c_occ_4", 32'(occ0), 4);
    tick();
    or0 = 1'b1; #1;
    check("t2c_out_a", od0, VA);
    tick();
    check("t2c_out_b", od0, VB);
    check("t2c_out_b_valid", 32'(ov0), 1);
    tick();
    check("t2c_out_c", od0, VC);
    tick();
    check("t2c_out_d", od0, VD);
    check("t2c_out_d_valid", 32'(ov0), 1);
    tick();
    check("t2c_empty", 32'(ov0), 0);
`else
    for (int s = 0; s < 3; s++) begin
      #1;
      check("t2_in_ready_stalled", 32'(ir0), 0);
      check("t2_head_a", od0, VA);
      check("t2_head_valid", 32'(ov0), 1);
      check("t2_occ_2", 32'(occ0), 2);
      tick();
    end
    or0 = 1'b1; #1;
    check("t2_out_a", od0, VA);
    tick();
    check("t2_gap", 32'(ov0), 0);
    tick();
    check("t2_out_b_valid", 32'(ov0), 1);
    check("t2_out_b", od0, VB);
`endif
    repeat (5) tick();
    check("t2_drained", 32'(occ0), 0);

    // Flush with three entries in flight.
    for (int k = 0; k < 3; k++) begin
      iv0 = 1'b1; id0 = 32'h11 + k; tick();
    end
    check("t3_occ_3", 32'(occ0), 3);
    flush0 = 1'b1; id0 = 32'h77; #1;
    check("t3_flush_in_ready", 32'(ir0), 0);
    check("t3_flush_out_valid", 32'(ov0), 0);
    tick();
    flush0 = 1'b0; iv0 = 1'b0; #1;
    check("t3_after_occ", 32'(occ0), 0);
    check("t3_after_out_valid", 32'(ov0), 0);
    iv0 = 1'b1; id0 = 32'h55; tick();
    iv0 = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      if (j < 4) check("t3_no_early_out", 32'(ov0), 0);
      else begin
        check("t3_new_valid", 32'(ov0), 1);
        check("t3_new_data", od0, 32'h55);
      end
      if (j < 4) tick();
    end
    repeat (4) tick();

    // DELAY=1: full register, simultaneous in/out handshake for ten cycles.
    or1 = 1'b0; iv1 = 1'b1; id1 = 100; #1;
    check("t4_empty_in_ready", 32'(ir1), 1);
    tick();
    for (int k = 0; k < 10; k++) begin
      iv1 = 1'b1; id1 = 101 + k; or1 = 1'b1; #1;
      check("t4_in_ready", 32'(ir1), 1);
      check("t4_out_valid", 32'(ov1), 1);
      check("t4_out_data", od1, 100 + k);
      check("t4_occ", 32'(occ1), 1);
      tick();
    end
    iv1 = 1'b0; or1 = 1'b0; #1;
    check("t4_last_data", od1, 110);
    check("t4_full_in_ready", 32'(ir1), 0);
    tick();
    or1 = 1'b1; tick();
    check("t4_empty", 32'(ov1), 0);

    // Async reset pulse between edges with three entries in flight.
    for (int k = 0; k < 3; k++) begin
      iv0 = 1'b1; id0 = 32'h21 + k; tick();
    end
    iv0 = 1'b0;
    check("t5_occ_3", 32'(occ0), 3);
    resetn = 1'b0; #1;
    check("t5_rst_out_valid", 32'(ov0), 0);
    check("t5_rst_occ", 32'(occ0), 0);
    check("t5_rst_out_data", od0, 0);
    check("t5_rst_in_ready", 32'(ir0), 0);
    resetn = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      check("t5_no_stale", 32'(ov0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/value_delay_pipe.md
# value_delay_pipe

Elastic, parametrised successor to the plain fixed-delay line in the float datapath. It carries a `VALUE_SIZE`-bit value through `DELAY` register stages with per-stage valid tracking, valid/ready backpressure, a synchronous flush and an occupancy count. It sits beside the pipelined float units: it delays interim operands alongside them and keeps them aligned when downstream stalls.

## Interface
Parameters:
- `VALUE_SIZE`, 32: data width in bits (≥1).
- `DELAY`, 4: number of register stages (≥1); stage 0 is the input side, stage `DELAY-1` drives the outputs.
- `CNT_W`, `$clog2(DELAY+1)`: occupancy width (localparam, not overridable).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous clear of all stages.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  stage 0 accepts this cycle.
- `in_data`  in  `VALUE_SIZE`  input value.
- `out_valid`  out  1  stage `DELAY-1` holds valid data.
- `out_ready`  in  1  consumer accepts this cycle.
- `out_data`  out  `VALUE_SIZE`  stage `DELAY-1` data.
- `occupancy`  out  `CNT_W`  number of valid stages, 0..`DELAY`.

## Operation
- Each stage `i` holds `v[i]` (valid) and `d[i]` (data). `out_valid = v[DELAY-1] & ~flush`; `out_data = d[DELAY-1]`.
- The input handshake fires on `in_valid & in_ready`. The output handshake fires on `out_valid & out_ready`.
- Advance rule with the macro undefined (global stall): `adv = ~v[DELAY-1] | out_ready`.
  - When `adv` is high, every stage shifts: `v[0]<=in_valid`, `d[0]<=in_data`, and `v[i]<=v[i-1]`, `d[i]<=d[i-1]`.
  - When `adv` is low, all stages hold.
  - `in_ready = adv & ~flush`.
- A stage loaded with an invalid entry still takes the data; its content is don't-care, but it must be deterministic from inputs.
- `flush` high: on the next edge all `v[i]<=0` and `occupancy<=0`. `d[i]` is unchanged. `in_ready` and `out_valid` are forced 0 during the flush cycle, so no handshake occurs. Flush has priority over every advance.
- `occupancy` next value = current + input handshake − output handshake. It never exceeds `DELAY` or goes below 0. It must equal the popcount of `v` at all times; the bench checks this.
- Reset (`resetn` low, asynchronous): all `v[i]=0`, all `d[i]=0`, `occupancy=0`. Outputs immediately read `out_valid=0`, `out_data=0`, `in_ready=0`. `in_ready` rises with `adv` after reset deasserts. Reset asserted mid-stream discards all contents with no output handshake.

## Timing
- Latency: an entry accepted at edge N appears with `out_valid=1` after edge N+`DELAY-1`. It is visible in the cycle following edge N+`DELAY-1`, i.e. `DELAY` cycles after the cycle it was presented in, when unstalled. This matches the fixed-delay line.
- Throughput is 1 entry per cycle while `out_ready=1`.
- `in_ready` is combinational from `out_ready`, `flush` and state. There is no combinational path from `in_valid` or `in_data` to any output.
- A simultaneous input and output handshake when full (`occupancy=DELAY`) is legal in both modes. Occupancy stays at `DELAY`.
- With `DELAY=1`, the block is a single elastic register: `in_ready = ~v[0] | out_ready`.

## Configuration
- `VALUE_DELAY_BUBBLE_COLLAPSE_EN` defined: each stage advances independently.
  - `adv[DELAY-1] = ~v[DELAY-1] | out_ready`.
  - `adv[i] = ~v[i] | adv[i+1]`.
  - Stage `i` loads from stage `i-1` (or from the input for `i=0`) when `adv[i]`. When stage `i+1` loads but stage `i` does not, `v[i]` clears.
  - `in_ready = adv[0] & ~flush`.
  - Bubbles compress during a stall, so the input keeps accepting until all `DELAY` stages are valid.
- Undefined: global stall as in Operation. Bubbles are preserved and inter-entry spacing is kept exactly. This is required when the delay must stay cycle-aligned with a sibling pipeline.

## Test plan
- Reset alignment:
  - Stimulus: `DELAY=4`; hold `resetn` low, then release and stream values 1,2,3… with `out_ready=1`.
  - Response: `out_valid=0` and `out_data=0` during reset. Value 1 appears 4 cycles after it was presented, then one value per cycle. `occupancy` settles at 4.
- Stall, macro undefined:
  - Stimulus: present A, idle, B; drop `out_ready` when A reaches the output, hold for 3 cycles, then raise it.
  - Response: `in_ready=0` for those 3 cycles. A and B leave exactly 2 cycles apart. `occupancy` stays at 2.
- Stall, macro defined:
  - Stimulus: same sequence, with new inputs C, D offered during the stall.
  - Response: the bubble collapses. C and D are accepted until `occupancy=4`, and `in_ready` then drops. Output order is A, B, C, D with no loss.
- Flush:
  - Stimulus: with `occupancy=3`, assert `flush` for 1 cycle with `in_valid=1` and `out_ready=1`.
  - Response: no handshake in that cycle. Next cycle `occupancy=0` and `out_valid=0`. The next accepted value appears after `DELAY` cycles.
- Full simultaneous handshake:
  - Stimulus: `DELAY=1`, `v[0]=1`, `in_valid=1`, `out_ready=1` held for 10 cycles.
  - Response: 10 transfers, `occupancy=1` throughout, in-order data.
- Async reset mid-stream:
  - Stimulus: pulse `resetn` low for 1 ns between edges while `occupancy=3`.
  - Response: `out_valid=0` and `occupancy=0` immediately. No stale value ever reaches the output.
